// File: rtl/conv2_k_mem_write_if.sv
// Loader stream and weight-RAM write bus for conv2_k_mem_write.
// The csum signal exists only when CONV2_KW_CHECKSUM_EN is defined.
interface conv2_k_mem_write_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;
`ifdef CONV2_KW_CHECKSUM_EN
  logic [23:0]       csum;
`endif

  modport slave (
`ifdef CONV2_KW_CHECKSUM_EN
    output csum,
`endif
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, done
  );

  modport master (
`ifdef CONV2_KW_CHECKSUM_EN
    input  csum,
`endif
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, done
  );
endinterface

// File: rtl/conv2_k_mem_write.sv
// Converts a serial weight stream into linear conv2 weight-RAM writes (addr = k*KSIZE+i).
// Optional CONV2_KW_CHECKSUM_EN adds a modulo-2^24 sum of accepted words on bus.csum.
module conv2_k_mem_write #(
  parameter int DATA_W = 16,
  parameter int KSIZE  = 25,
  parameter int NKERN  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  conv2_k_mem_write_if.slave     bus
);
  localparam int         TOTAL = NKERN * KSIZE;
  localparam logic [7:0] LAST  = 8'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_reg;
  logic [7:0]        count_reg;
  logic              wr_en_reg;
  logic [7:0]        wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              done_reg;
`ifdef CONV2_KW_CHECKSUM_EN
  logic [23:0]       csum_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      done_reg    <= 1'b0;
`ifdef CONV2_KW_CHECKSUM_EN
      csum_reg    <= '0;
`endif
    end else begin
      wr_en_reg <= 1'b0;
      if (clear) begin
        // Abort wins over start and over a beat presented on the same edge.
        state_reg <= IDLE;
        count_reg <= '0;
        done_reg  <= 1'b0;
`ifdef CONV2_KW_CHECKSUM_EN
        csum_reg  <= '0;
`endif
      end else begin
        case (state_reg)
          LOAD: begin
            if (bus.in_valid) begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= count_reg;
              wr_data_reg <= bus.in_data;
`ifdef CONV2_KW_CHECKSUM_EN
              csum_reg    <= csum_reg + 24'(bus.in_data);
`endif
              if (count_reg == LAST) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end else begin
                count_reg <= count_reg + 8'd1;
              end
            end
          end
          default: begin
            if (start) begin
              state_reg <= LOAD;
              count_reg <= '0;
              done_reg  <= 1'b0;
`ifdef CONV2_KW_CHECKSUM_EN
              csum_reg  <= '0;
`endif
            end
          end
        endcase
      end
    end
  end

  assign bus.in_ready = (state_reg == LOAD);
  assign bus.wr_en    = wr_en_reg;
  assign bus.wr_addr  = wr_addr_reg;
  assign bus.wr_data  = wr_data_reg;
  assign bus.done     = done_reg;
`ifdef CONV2_KW_CHECKSUM_EN
  assign bus.csum     = csum_reg;
`endif
endmodule
